// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a single UART sender.
// It grants one frame, pulses send_en, then tracks tx_busy with a bounded wait.
module uart_tx_arb #(
    parameter int DATA_W   = 128,
    parameter int BUSY_TMO = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              tx_busy,
    output logic              send_en,
    output logic [DATA_W-1:0] send_data,
    output logic              grant_id,
    output logic              tmo_err
);

    localparam int CNT_W = $clog2(BUSY_TMO + 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(BUSY_TMO);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             winner;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        winner  = (req0 && req1) ? ~grant_id : req1;
        cnt_nxt = (cnt == TMO_VAL) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            send_en   <= 1'b0;
            send_data <= '0;
            grant_id  <= 1'b1;
            tmo_err   <= 1'b0;
        end else begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            send_en <= 1'b0;
            tmo_err <= 1'b0;
            case (state)
                IDLE: begin
                    if ((req0 || req1) && !tx_busy) begin
                        grant_id  <= winner;
                        send_data <= winner ? data1 : data0;
                        ack0      <= ~winner;
                        ack1      <= winner;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    send_en <= 1'b1;
                    cnt     <= '0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    cnt <= cnt_nxt;
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt_nxt == TMO_VAL) begin
                        // Sender never answered: give up and let the next frame through.
                        tmo_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized traffic,
// all checked each cycle against a transaction-timestamp model.
module tb_uart_tx_arb;

    localparam int DW  = 128;
    localparam int TMO = 8;
    localparam logic [DW-1:0] A5 = {16{8'hA5}};

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, tx_busy = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          ack0, ack1, send_en, grant_id, tmo_err;
    logic [DW-1:0] send_data;

    int n_chk = 0;
    int n_fail = 0;

    uart_tx_arb #(.DATA_W(DW), .BUSY_TMO(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .tx_busy(tx_busy), .send_en(send_en), .send_data(send_data),
        .grant_id(grant_id), .tmo_err(tmo_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: a transfer is a grant timestamp; every later event is an offset from it.
    bit            m_xfer = 0, m_seen = 0;
    int            m_cyc = 0, m_g = 0, m_k = 0;
    logic          m_w;
    logic          m_gid = 1'b1;
    logic [DW-1:0] m_data = '0;
    logic          m_ack0 = 0, m_ack1 = 0, m_se = 0, m_tmo = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_xfer = 0; m_seen = 0; m_cyc = 0; m_gid = 1'b1; m_data = '0;
            m_ack0 = 0; m_ack1 = 0; m_se = 0; m_tmo = 0;
        end else begin
            m_cyc++;
            m_ack0 = 0; m_ack1 = 0; m_se = 0; m_tmo = 0;
            if (!m_xfer) begin
                if ((req0 || req1) && !tx_busy) begin
                    m_w    = (req0 && req1) ? !m_gid : req1;
                    m_gid  = m_w;
                    m_data = m_w ? data1 : data0;
                    if (m_w) m_ack1 = 1; else m_ack0 = 1;
                    m_xfer = 1; m_seen = 0; m_g = m_cyc;
                end
            end else begin
                m_k = m_cyc - m_g;
                if (m_k == 1) m_se = 1;
                else if (!m_seen) begin
                    if (tx_busy) m_seen = 1;
                    else if (m_k - 1 == TMO) begin m_tmo = 1; m_xfer = 0; end
                end else if (!tx_busy) m_xfer = 0;
            end
        end
    end

    always @(negedge sys_clk) begin
        n_chk++;
        if ({ack0, ack1, send_en, tmo_err, grant_id} !== {m_ack0, m_ack1, m_se, m_tmo, m_gid}
            || send_data !== m_data) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got ack0=%b ack1=%b se=%b tmo=%b gid=%b data=%h expected ack0=%b ack1=%b se=%b tmo=%b gid=%b data=%h",
                     $time, ack0, ack1, send_en, tmo_err, grant_id, send_data,
                     m_ack0, m_ack1, m_se, m_tmo, m_gid, m_data);
        end
        n_chk++;
        if (ack0 && ack1) begin
            n_fail++;
            $display("FAIL double_ack t=%0t got ack0=1 ack1=1 expected at most one", $time);
        end
    end

    task automatic step();
        @(posedge sys_clk); #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 0; req0 = 0; req1 = 0; tx_busy = 0;
        step();
        step();
        sys_rst_n = 1;
    endtask

    int t_se, t_tmo, n_se, n_gr, bdelay, blen;

    initial begin
        // Reset values and single request with sender handshake
        sys_rst_n = 0;
        step();
        chk("rst_gid", grant_id, 1);
        chk("rst_data", send_data, 0);
        chk("rst_outs", {ack0, ack1, send_en, tmo_err}, 0);
        step();
        sys_rst_n = 1;
        data0 = A5; req0 = 1;
        step();
        chk("d1_ack0", ack0, 1);
        chk("d1_se_early", send_en, 0);
        chk("d1_gid", grant_id, 0);
        chk("d1_data", send_data, A5);
        req0 = 0;
        step();
        chk("d1_ack_pulse", ack0, 0);
        chk("d1_se", send_en, 1);
        step();
        chk("d1_se_pulse", send_en, 0);
        step();
        tx_busy = 1;
        repeat (10) step();
        tx_busy = 0; req0 = 1; data0 = ~A5;
        step();
        chk("d1_no_early_grant", ack0, 0);
        chk("d1_data_hold", send_data, A5);
        step();
        chk("d1_regrant", ack0, 1);
        chk("d1_data2", send_data, ~A5);
        req0 = 0;
        repeat (TMO + 4) step();

        // Timeout with a silent sender, then re-grant of the held request
        do_reset();
        req1 = 1; data1 = {$urandom, $urandom, $urandom, $urandom};
        t_se = -1; t_tmo = -1; n_se = 0;
        for (int i = 0; i < 60 && t_tmo < 0; i++) begin
            step();
            if (send_en) begin n_se++; if (t_se < 0) t_se = i; end
            if (tmo_err) t_tmo = i;
        end
        chk("tmo_seen", t_tmo >= 0, 1);
        chk("tmo_one_send", n_se, 1);
        chk("tmo_latency", t_tmo - t_se, TMO);
        step();
        chk("tmo_pulse", tmo_err, 0);
        chk("tmo_regrant", ack1, 1);
        req1 = 0;
        repeat (TMO + 4) step();

        // Contention: strict alternation starting with requester 0
        do_reset();
        req0 = 1; req1 = 1;
        n_gr = 0;
        for (int i = 0; i < 200 && n_gr < 4; i++) begin
            step();
            if (ack0 || ack1) begin
                chk("cont_ack", {ack0, ack1}, (n_gr % 2) ? 2'b01 : 2'b10);
                chk("cont_gid", grant_id, n_gr % 2);
                n_gr++;
            end
        end
        chk("cont_count", n_gr, 4);
        req0 = 0; req1 = 0;
        repeat (TMO + 4) step();

        // Foreign busy blocks grants in IDLE
        do_reset();
        tx_busy = 1; req0 = 1; data0 = A5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fb_hold", ack0, 0);
        end
        tx_busy = 0;
        step();
        chk("fb_grant", ack0, 1);
        req0 = 0;
        repeat (TMO + 4) step();

        // Reset during WAIT_DONE
        do_reset();
        req0 = 1; data0 = A5;
        step(); step(); step();
        tx_busy = 1;
        step(); step();
        #2 sys_rst_n = 0;
        #1;
        chk("rst_mid_outs", {ack0, ack1, send_en, tmo_err}, 0);
        chk("rst_mid_gid", grant_id, 1);
        chk("rst_mid_data", send_data, 0);
        tx_busy = 0;
        step();
        sys_rst_n = 1;
        step();
        chk("rst_mid_regrant", ack0, 1);
        req0 = 0;
        repeat (TMO + 4) step();

        // Randomized traffic with a responding sender
        do_reset();
        bdelay = -1; blen = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 499) == 0) begin
                sys_rst_n = 0; req0 = 0; req1 = 0; tx_busy = 0; bdelay = -1; blen = 0;
                step();
                sys_rst_n = 1;
                continue;
            end
            if (send_en) bdelay = $urandom_range(1, TMO + 2);
            else if (bdelay > 0) begin
                bdelay--;
                if (bdelay == 0) begin blen = $urandom_range(1, 6); bdelay = -1; end
            end else if (blen == 0 && $urandom_range(0, 19) == 0) blen = $urandom_range(1, 4);
            tx_busy = (blen > 0);
            if (blen > 0) blen--;

            if (!req0) begin
                if ($urandom_range(0, 3) == 0) begin req0 = 1; data0 = {$urandom, $urandom, $urandom, $urandom}; end
            end else if (ack0) begin
                if ($urandom_range(0, 1) == 0) req0 = 0;
                else data0 = {$urandom, $urandom, $urandom, $urandom};
            end else if ($urandom_range(0, 39) == 0) req0 = 0;

            if (!req1) begin
                if ($urandom_range(0, 3) == 0) begin req1 = 1; data1 = {$urandom, $urandom, $urandom, $urandom}; end
            end else if (ack1) begin
                if ($urandom_range(0, 1) == 0) req1 = 0;
                else data1 = {$urandom, $urandom, $urandom, $urandom};
            end else if ($urandom_range(0, 39) == 0) req1 = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
